// File: rtl/asg_burst_gen.sv
// asg_burst_gen: arbitrary signal generator, sample table replayed as AXI4-stream.
// Optional ASG_BUS_READBACK_EN: bus reads return table contents (2-cycle ack).
module asg_burst_gen #(
  parameter int DN  = 1,
  parameter int DWO = 14,
  parameter int CWM = 14,
  parameter int CWF = 16,
  parameter int CWL = 32,
  parameter int CWN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctl_rst,
  input  logic                 ctl_str,
  input  logic                 ctl_stp,
  input  logic                 ctl_trg,
  output logic                 sts_str,
  output logic                 sts_stp,
  output logic                 sts_trg,
  output logic                 evn_per,
  output logic                 evn_lst,
  input  logic [CWM+CWF-1:0]   cfg_siz,
  input  logic [CWM+CWF-1:0]   cfg_stp,
  input  logic [CWM+CWF-1:0]   cfg_off,
  input  logic                 cfg_ben,
  input  logic                 cfg_inf,
  input  logic [CWM-1:0]       cfg_bdl,
  input  logic [CWL-1:0]       cfg_bln,
  input  logic [CWN-1:0]       cfg_bnm,
  output logic [CWL-1:0]       sts_bln,
  output logic [CWN-1:0]       sts_bnm,
  output logic                 sts_run,
  output logic [DN*DWO-1:0]    sto_tdata,
  output logic [DN-1:0]        sto_tkeep,
  output logic                 sto_tlast,
  output logic                 sto_tvalid,
  input  logic                 sto_tready,
  input  logic                 bus_wen,
  input  logic                 bus_ren,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ack
);

  localparam int PW = CWM + CWF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CWL-1:0]   gbln_q, gbln_d;
  logic [CWN-1:0]   gbnm_q, gbnm_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_per_q, s1_per_d;
  logic             out_v_q, out_v_d;
  logic [DWO-1:0]   out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_per_q, out_per_d;
  logic [CWL-1:0]   bln_q, bln_d;
  logic [CWN-1:0]   bnm_q, bnm_d;
  logic             evn_per_q, evn_per_d;
  logic             evn_lst_q, evn_lst_d;
  logic             trg_q, trg_d;
  logic             stp_q, stp_d;
  logic             ack_q, ack_d;

  logic [DWO-1:0]   tbl [2**CWM];
  logic [DWO-1:0]   smp_q;
  logic [CWM-1:0]   gen_addr;
  logic [CWM-1:0]   rd_addr;
  logic [PW-1:0]    ptr_nxt;
  logic             clr, start, stop_now;
  logic             adv, hs, issue, blk;
  logic             gen_per, gen_fin;
  logic             unused_bits;

`ifdef ASG_BUS_READBACK_EN
  logic             rd_pend_q, rd_pend_d;
  logic             rdv_q, rdv_d;
  logic [CWM-1:0]   raddr_q, raddr_d;
  logic [DWO-1:0]   brd_q;
`endif

  assign unused_bits = ^{bus_addr[31:CWM+2], bus_addr[1:0],
                         bus_wdata[31:DWO]};

  assign clr      = rst | ctl_rst;
  assign start    = (state_q == ST_IDLE) & (ctl_str | ctl_trg);
  assign stop_now = ctl_stp &
                    ((state_q == ST_RUN) | (state_q == ST_DRAIN));
  assign adv      = ~out_v_q | sto_tready;
  assign hs       = out_v_q & sto_tready;
  assign gen_per  = (gbln_q == cfg_bln);
  assign gen_fin  = gen_per & ~cfg_inf & (gbnm_q == cfg_bnm);
  assign issue    = (state_q == ST_RUN) & ~ctl_stp &
                    (~s1_v_q | adv) & ~blk;

`ifdef ASG_BUS_READBACK_EN
  assign blk = rd_pend_q;
`else
  assign blk = 1'b0;
`endif

  // Next fixed-point pointer, folded back into the table window.
  always_comb begin
    logic [PW:0] sum;
    logic [PW:0] siz;
    siz = {1'b0, cfg_siz};
    sum = {1'b0, ptr_q} + {1'b0, cfg_stp} + (PW+1)'(1);
    if (sum > siz) begin
      sum = sum - siz - (PW+1)'(1);
    end
    ptr_nxt = sum[PW-1:0];
  end

  // Table address: pointer integer part, or clamped burst position.
  always_comb begin
    gen_addr = ptr_q[PW-1:CWF];
    if (cfg_ben) begin
      gen_addr = (gbln_q > CWL'(cfg_bdl)) ? cfg_bdl
                                           : gbln_q[CWM-1:0];
    end
    rd_addr = gen_addr;
`ifdef ASG_BUS_READBACK_EN
    if (rd_pend_q) begin
      rd_addr = raddr_q;
    end
`endif
  end

  // Control FSM, generator, pipeline and status next-state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gbln_d     = gbln_q;
    gbnm_d     = gbnm_q;
    s1_v_d     = s1_v_q;
    s1_last_d  = s1_last_q;
    s1_per_d   = s1_per_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_per_d  = out_per_q;
    bln_d      = bln_q;
    bnm_d      = bnm_q;
    evn_per_d  = 1'b0;
    evn_lst_d  = 1'b0;
    trg_d      = 1'b0;
    stp_d      = 1'b0;

    if (adv) begin
      out_v_d    = s1_v_q & ~stop_now;
      out_last_d = s1_v_q & s1_last_q & ~stop_now;
      out_per_d  = s1_v_q & s1_per_q & ~stop_now;
      if (s1_v_q) begin
        out_data_d = smp_q;
      end
    end

    if (hs) begin
      evn_per_d = out_per_q;
      evn_lst_d = out_last_q;
      if (cfg_ben) begin
        if (out_per_q) begin
          bln_d = '0;
          bnm_d = bnm_q + CWN'(1);
        end else begin
          bln_d = bln_q + CWL'(1);
        end
      end
    end

    if (issue) begin
      s1_v_d = 1'b1;
      if (cfg_ben) begin
        s1_per_d  = gen_per;
        s1_last_d = gen_fin;
        if (gen_per) begin
          gbln_d = '0;
          gbnm_d = gbnm_q + CWN'(1);
        end else begin
          gbln_d = gbln_q + CWL'(1);
        end
      end else begin
        s1_per_d  = 1'b0;
        s1_last_d = 1'b0;
        ptr_d     = ptr_nxt;
      end
    end else if (adv | stop_now) begin
      s1_v_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ptr_d   = cfg_off;
          gbln_d  = '0;
          gbnm_d  = '0;
          bln_d   = '0;
          bnm_d   = '0;
          trg_d   = ctl_trg;
        end
      end
      ST_RUN: begin
        if (ctl_stp) begin
          state_d = ST_STOP;
        end else if (issue & cfg_ben & gen_fin) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ctl_stp) begin
          state_d = ST_STOP;
        end else if (~s1_v_q & (~out_v_q | hs)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (~out_v_q | hs) begin
          state_d = ST_IDLE;
          stp_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus handshake next-state.
  always_comb begin
`ifdef ASG_BUS_READBACK_EN
    rd_pend_d = bus_ren;
    rdv_d     = rd_pend_q;
    raddr_d   = bus_ren ? bus_addr[CWM+1:2] : raddr_q;
    ack_d     = bus_wen | rd_pend_q;
`else
    ack_d     = bus_wen | bus_ren;
`endif
  end

  // State registers; either reset source returns everything to idle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gbln_q     <= '0;
      gbnm_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_per_q   <= 1'b0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_per_q  <= 1'b0;
      bln_q      <= '0;
      bnm_q      <= '0;
      evn_per_q  <= 1'b0;
      evn_lst_q  <= 1'b0;
      trg_q      <= 1'b0;
      stp_q      <= 1'b0;
      ack_q      <= 1'b0;
`ifdef ASG_BUS_READBACK_EN
      rd_pend_q  <= 1'b0;
      rdv_q      <= 1'b0;
      raddr_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gbln_q     <= gbln_d;
      gbnm_q     <= gbnm_d;
      s1_v_q     <= s1_v_d;
      s1_last_q  <= s1_last_d;
      s1_per_q   <= s1_per_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_per_q  <= out_per_d;
      bln_q      <= bln_d;
      bnm_q      <= bnm_d;
      evn_per_q  <= evn_per_d;
      evn_lst_q  <= evn_lst_d;
      trg_q      <= trg_d;
      stp_q      <= stp_d;
      ack_q      <= ack_d;
`ifdef ASG_BUS_READBACK_EN
      rd_pend_q  <= rd_pend_d;
      rdv_q      <= rdv_d;
      raddr_q    <= raddr_d;
`endif
    end
  end

  // Sample table: bus write port, one shared registered read port.
  always_ff @(posedge clk) begin
    if (bus_wen) begin
      tbl[bus_addr[CWM+1:2]] <= bus_wdata[DWO-1:0];
    end
    if (issue) begin
      smp_q <= tbl[rd_addr];
    end
`ifdef ASG_BUS_READBACK_EN
    if (rd_pend_q) begin
      brd_q <= tbl[rd_addr];
    end
`endif
  end

  assign sts_run    = (state_q != ST_IDLE);
  assign sts_str    = sts_run;
  assign sts_stp    = stp_q;
  assign sts_trg    = trg_q;
  assign evn_per    = evn_per_q;
  assign evn_lst    = evn_lst_q;
  assign sts_bln    = bln_q;
  assign sts_bnm    = bnm_q;
  assign sto_tdata  = {DN{out_data_q}};
  assign sto_tkeep  = {DN{1'b1}};
  assign sto_tlast  = out_last_q;
  assign sto_tvalid = out_v_q;
  assign bus_ack    = ack_q;

`ifdef ASG_BUS_READBACK_EN
  assign bus_rdata = rdv_q ? {{(32-DWO){brd_q[DWO-1]}}, brd_q} : '0;
`else
  assign bus_rdata = '0;
`endif

endmodule

// File: tb/tb_asg_burst_gen.sv
// tb_asg_burst_gen: scoreboard bench for asg_burst_gen.
// Table holds table[i]=i; expected beats queued per case.
module tb_asg_burst_gen;

  localparam int DWO = 14;
  localparam int CWM = 14;
  localparam int CWF = 16;
  localparam int CWL = 32;
  localparam int CWN = 16;
  localparam int PW  = CWM + CWF;

  logic              clk = 1'b0;
  logic              rst, ctl_rst, ctl_str, ctl_stp, ctl_trg;
  logic              sts_str, sts_stp, sts_trg, evn_per, evn_lst;
  logic [PW-1:0]     cfg_siz, cfg_stp, cfg_off;
  logic              cfg_ben, cfg_inf;
  logic [CWM-1:0]    cfg_bdl;
  logic [CWL-1:0]    cfg_bln;
  logic [CWN-1:0]    cfg_bnm;
  logic [CWL-1:0]    sts_bln;
  logic [CWN-1:0]    sts_bnm;
  logic              sts_run;
  logic [DWO-1:0]    sto_tdata;
  logic [0:0]        sto_tkeep;
  logic              sto_tlast, sto_tvalid, sto_tready;
  logic              bus_wen, bus_ren;
  logic [31:0]       bus_addr, bus_wdata, bus_rdata;
  logic              bus_ack;

  asg_burst_gen dut (
    .clk(clk), .rst(rst), .ctl_rst(ctl_rst), .ctl_str(ctl_str),
    .ctl_stp(ctl_stp), .ctl_trg(ctl_trg), .sts_str(sts_str),
    .sts_stp(sts_stp), .sts_trg(sts_trg), .evn_per(evn_per),
    .evn_lst(evn_lst), .cfg_siz(cfg_siz), .cfg_stp(cfg_stp),
    .cfg_off(cfg_off), .cfg_ben(cfg_ben), .cfg_inf(cfg_inf),
    .cfg_bdl(cfg_bdl), .cfg_bln(cfg_bln), .cfg_bnm(cfg_bnm),
    .sts_bln(sts_bln), .sts_bnm(sts_bnm), .sts_run(sts_run),
    .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep),
    .sto_tlast(sto_tlast), .sto_tvalid(sto_tvalid),
    .sto_tready(sto_tready), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct packed {
    logic [DWO-1:0] d;
    logic           l;
    logic           p;
  } beat_t;

  beat_t          q[$];
  int             checks = 0;
  int             errors = 0;
  int             pops = 0;
  logic           prev_hs = 1'b0;
  logic           prev_per = 1'b0;
  logic           prev_lst = 1'b0;
  logic           stall = 1'b0;
  logic           rdy_rand = 1'b0;
  logic [DWO-1:0] held_d = '0;
  logic           held_l = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sts_run; i++) tick();
    chk("idle_reached", 32'(sts_run), 32'(0));
  endtask

  task automatic run_burst(input int bdl, input int bln, input int bnm);
    beat_t b;
    cfg_ben = 1'b1;
    cfg_inf = 1'b0;
    cfg_bdl = CWM'(bdl);
    cfg_bln = CWL'(bln);
    cfg_bnm = CWN'(bnm);
    for (int p = 0; p <= bnm; p++) begin
      for (int k = 0; k <= bln; k++) begin
        b.d = DWO'((k < bdl) ? k : bdl);
        b.l = (p == bnm) && (k == bln);
        b.p = (k == bln);
        q.push_back(b);
      end
    end
    ctl_trg = 1'b1;
    tick();
    ctl_trg = 1'b0;
    chk("sts_trg", 32'(sts_trg), 32'(1));
    chk("run_start", 32'(sts_run), 32'(1));
    chk("lat0_valid", 32'(sto_tvalid), 32'(0));
    tick();
    chk("lat1_valid", 32'(sto_tvalid), 32'(0));
    tick();
    chk("lat2_valid", 32'(sto_tvalid), 32'(1));
    wait_idle((bln + 1) * (bnm + 1) + 20);
    chk("q_empty", 32'(q.size()), 32'(0));
    chk("bnm_done", 32'(sts_bnm), 32'(bnm + 1));
    chk("bln_done", sts_bln, 32'(0));
    tick();
    tick();
    chk("run_low", 32'(sts_run), 32'(0));
    chk("valid_low", 32'(sto_tvalid), 32'(0));
  endtask

  // Ready driver: always-ready or random backpressure.
  initial begin
    sto_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sto_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: events, hold-while-stalled, scoreboard pop.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (prev_hs) begin
        chk("evn_per", 32'(evn_per), 32'(prev_per));
        chk("evn_lst", 32'(evn_lst), 32'(prev_lst));
      end
      prev_hs = 1'b0;
      if (stall) begin
        chk("hold_data", 32'(sto_tdata), 32'(held_d));
        chk("hold_last", 32'(sto_tlast), 32'(held_l));
      end
      stall  = (sto_tvalid === 1'b1) && (sto_tready === 1'b0);
      held_d = sto_tdata;
      held_l = sto_tlast;
      if ((sto_tvalid === 1'b1) && (sto_tready === 1'b1)) begin
        chk("beat_expected", 32'(q.size() != 0), 32'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          pops++;
          chk("tdata", 32'(sto_tdata), 32'(e.d));
          chk("tlast", 32'(sto_tlast), 32'(e.l));
          chk("tkeep", 32'(sto_tkeep), 32'(1));
          chk("run_on_beat", 32'(sts_run), 32'(1));
          prev_hs  = 1'b1;
          prev_per = e.p;
          prev_lst = e.l;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic  saw;
    beat_t b;
    rst = 1'b1; ctl_rst = 1'b0; ctl_str = 1'b0;
    ctl_stp = 1'b0; ctl_trg = 1'b0;
    cfg_siz = '0; cfg_stp = '0; cfg_off = '0;
    cfg_ben = 1'b0; cfg_inf = 1'b0;
    cfg_bdl = '0; cfg_bln = '0; cfg_bnm = '0;
    bus_wen = 1'b0; bus_ren = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", 32'(sto_tvalid), 32'(0));
    chk("rst_last", 32'(sto_tlast), 32'(0));
    chk("rst_run", 32'(sts_run), 32'(0));
    chk("rst_str", 32'(sts_str), 32'(0));
    chk("rst_bln", sts_bln, 32'(0));
    chk("rst_bnm", 32'(sts_bnm), 32'(0));
    chk("rst_ack", 32'(bus_ack), 32'(0));

    for (int i = 0; i < 2**CWM; i++) begin
      bus_wen   = 1'b1;
      bus_addr  = 32'(i) << 2;
      bus_wdata = 32'(i);
      tick();
    end
    bus_wen = 1'b0;
    chk("wr_ack", 32'(bus_ack), 32'(1));
    tick();
    chk("wr_ack_clr", 32'(bus_ack), 32'(0));

    bus_ren  = 1'b1;
    bus_addr = 32'(5 << 2);
    tick();
    bus_ren = 1'b0;
`ifdef ASG_BUS_READBACK_EN
    chk("rd_ack_early", 32'(bus_ack), 32'(0));
    tick();
    chk("rd_ack", 32'(bus_ack), 32'(1));
    chk("rd_data", bus_rdata, 32'(5));
`else
    chk("rd_ack", 32'(bus_ack), 32'(1));
    chk("rd_data", bus_rdata, 32'(0));
`endif
    tick();
    chk("rd_ack_clr", 32'(bus_ack), 32'(0));

    for (int n = 1; n <= 4; n++) run_burst(0, 0, n - 1);
    run_burst(6, 7, 2);
    run_burst(7, 7, 3);

    cfg_ben = 1'b1; cfg_inf = 1'b1;
    cfg_bdl = '0; cfg_bln = CWL'(7); cfg_bnm = '0;
    for (int k = 0; k < 64; k++) begin
      b.d = '0; b.l = 1'b0; b.p = ((k % 8) == 7);
      q.push_back(b);
    end
    pops = 0;
    ctl_trg = 1'b1;
    tick();
    ctl_trg = 1'b0;
    repeat (40) tick();
    chk("inf_beats", 32'(pops > 8), 32'(1));
    chk("inf_run", 32'(sts_run), 32'(1));
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0;
    prev_hs = 1'b0;
    stall = 1'b0;
    q.delete();
    chk("srst_valid", 32'(sto_tvalid), 32'(0));
    chk("srst_run", 32'(sts_run), 32'(0));
    chk("srst_bnm", 32'(sts_bnm), 32'(0));
    chk("srst_bln", sts_bln, 32'(0));
    tick();
    chk("srst_hold", 32'(sto_tvalid), 32'(0));
    run_burst(0, 0, 1);

    cfg_ben = 1'b0; cfg_inf = 1'b0;
    cfg_stp = PW'(32'h0000_FFFF);
    cfg_off = '0;
    cfg_siz = PW'((20 << CWF) - 1);
    for (int k = 0; k < 60; k++) begin
      b.d = DWO'(k % 20); b.l = 1'b0; b.p = 1'b0;
      q.push_back(b);
    end
    rdy_rand = 1'b1;
    ctl_str = 1'b1;
    tick();
    ctl_str = 1'b0;
    chk("per_run", 32'(sts_run), 32'(1));
    chk("per_no_trg", 32'(sts_trg), 32'(0));
    for (int i = 0; i < 600 && q.size() > 10; i++) tick();
    chk("per_progress", 32'(q.size() <= 10), 32'(1));
    ctl_stp = 1'b1;
    tick();
    ctl_stp = 1'b0;
    saw = sts_stp;
    for (int i = 0; i < 40 && sts_run; i++) begin
      tick();
      saw = saw | sts_stp;
    end
    chk("stop_idle", 32'(sts_run), 32'(0));
    chk("stop_pulse", 32'(saw), 32'(1));
    rdy_rand = 1'b0;
    repeat (3) tick();
    chk("stop_quiet", 32'(sto_tvalid), 32'(0));
    q.delete();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
